// File: rtl/core_pkg.sv
// Core-wide constants and types shared by the pipeline front end.
//   XLEN      : architectural address/data width (alias of DATA_W)
//   RESET_PC  : default first fetch address after reset
//   NOP_INSTR : addi x0,x0,0, presented to ID when no real instruction is there
//   fetch_mode_e : per-cycle operating mode of the fetch unit
package core_pkg;
  localparam int              DATA_W    = 32;
  localparam int              XLEN      = DATA_W;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_STALL,
    MODE_REDIRECT
  } fetch_mode_e;
endpackage

// File: rtl/instruction_fetch_unit_hold_buffer.sv
// fetch_hold_buffer: one-entry buffer that keeps the ID-stage instruction
// stable across a stall, plus the ID instruction mux.
//   clk, rst_n : clock, synchronous active-low reset
//   stall      : IF/ID freeze request
//   flush      : redirect this cycle; overrides stall and empties the buffer
//   valid      : ID holds a real instruction (selects NOP otherwise)
//   rdata      : instruction memory read data
//   instr      : instruction presented to ID
module fetch_hold_buffer
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rdata,
  output logic [31:0] instr
);
  logic        hold_vld;
  logic [31:0] hold_instr;

  // First stalled cycle still sees the live read data for the ID
  // instruction; capture it then, because memory is disabled afterwards
  // and its output may change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_vld   <= 1'b0;
      hold_instr <= '0;
    end else if (flush || !stall) begin
      hold_vld   <= 1'b0;
    end else if (!hold_vld) begin
      hold_instr <= rdata;
      hold_vld   <= 1'b1;
    end
  end

  assign instr = !valid   ? NOP_INSTR  :
                 hold_vld ? hold_instr : rdata;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, drives a 1-cycle-latency instruction
// memory and presents pc/instr/valid to ID.
//   clk, rst_n          : clock, synchronous active-low reset
//   stall_i             : freeze IF and ID
//   redirect_valid_i/pc : taken branch/jump target from EX (bits [1:0] ignored)
//   imem_en_o/addr_o    : memory read request; imem_rdata_i returns next cycle
//   pc_ID_o, pc_plus4_ID_o, instr_ID_o, valid_ID_o : ID-stage outputs
module instruction_fetch_unit #(
  parameter int               XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_en_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] pc_ID_o,
  output logic [XLEN-1:0] pc_plus4_ID_o,
  output logic [31:0]     instr_ID_o,
  output logic            valid_ID_o
);
  import core_pkg::*;

  fetch_mode_e     mode;
  logic [XLEN-1:0] pc_f, pc_id, target, fetch_addr;
  logic            valid_id;

  always_comb begin
    mode = MODE_NORMAL;
    if (redirect_valid_i)  mode = MODE_REDIRECT;
    else if (stall_i)      mode = MODE_STALL;
  end

  assign target     = {redirect_pc_i[XLEN-1:2], 2'b00};
  // Redirect target bypasses pc_f so it is fetched in the same cycle.
  assign fetch_addr = (mode == MODE_REDIRECT) ? target : pc_f;

  assign imem_en_o   = rst_n && (mode != MODE_STALL);
  assign imem_addr_o = fetch_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f     <= RESET_PC;
      pc_id    <= '0;
      valid_id <= 1'b0;
    end else if (mode != MODE_STALL) begin
      pc_f     <= fetch_addr + XLEN'(4);
      pc_id    <= fetch_addr;
      valid_id <= 1'b1;
    end
  end

  // Outputs are forced to their reset values while rst_n is low, even
  // before the first reset edge has been seen.
  assign valid_ID_o    = rst_n && valid_id;
  assign pc_ID_o       = rst_n ? pc_id : '0;
  assign pc_plus4_ID_o = pc_ID_o + XLEN'(4);

  fetch_hold_buffer u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall_i),
    .flush (redirect_valid_i),
    .valid (valid_ID_o),
    .rdata (imem_rdata_i),
    .instr (instr_ID_o)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  logic        clk, rst_n, rst2_n, stall_i, redir_v;
  logic [31:0] redir_pc;
  logic        en, en2, vld, vld2;
  logic [31:0] addr, addr2, rdata, rdata2, pc, pc2, pc4, pc42, instr, instr2;
  int checks = 0;
  int failures = 0;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_valid_i(redir_v),
    .redirect_pc_i(redir_pc), .imem_en_o(en), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .pc_ID_o(pc), .pc_plus4_ID_o(pc4),
    .instr_ID_o(instr), .valid_ID_o(vld));

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall_i(stall_i), .redirect_valid_i(redir_v),
    .redirect_pc_i(redir_pc), .imem_en_o(en2), .imem_addr_o(addr2),
    .imem_rdata_i(rdata2), .pc_ID_o(pc2), .pc_plus4_ID_o(pc42),
    .instr_ID_o(instr2), .valid_ID_o(vld2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word i = 32'h1000_0000 + i; garbage whenever the read is disabled.
  always @(posedge clk) begin
    rdata  <= en  ? 32'h1000_0000 + {2'b00, addr[31:2]}  : 32'hDEAD_BEEF;
    rdata2 <= en2 ? 32'h1000_0000 + {2'b00, addr2[31:2]} : 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; rst2_n = 0; stall_i = 0; redir_v = 0; redir_pc = '0;
    #1;
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL rst_en_pre got=%b want=0", en); end
    step(); step();
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b want=0", en); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b want=0", vld); end
    checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr got=%h want=00000013", instr); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h want=0", pc); end
    checks++; if (pc4 !== 32'h4) begin failures++; $display("FAIL rst_pc4 got=%h want=4", pc4); end
    rst_n = 1; #1;
    checks++; if (addr !== 32'h0 || en !== 1'b1) begin failures++; $display("FAIL rel_fetch got addr=%h en=%b want 0/1", addr, en); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rel_vld0 got=%b want=0", vld); end
    step();
    checks++; if (vld !== 1'b1 || pc !== 32'h0 || instr !== 32'h1000_0000) begin failures++; $display("FAIL first_id got vld=%b pc=%h instr=%h want 1/0/10000000", vld, pc, instr); end
    checks++; if (pc4 !== 32'h4) begin failures++; $display("FAIL first_pc4 got=%h want=4", pc4); end
    step();
    checks++; if (pc !== 32'h4 || instr !== 32'h1000_0001) begin failures++; $display("FAIL run1 got pc=%h instr=%h want 4/10000001", pc, instr); end
    step();
    checks++; if (pc !== 32'h8 || instr !== 32'h1000_0002) begin failures++; $display("FAIL run2 got pc=%h instr=%h want 8/10000002", pc, instr); end
  endtask

  task automatic test_stall();
    stall_i = 1; #1;
    checks++; if (en !== 1'b0 || addr !== 32'hC) begin failures++; $display("FAIL stall_req got en=%b addr=%h want 0/c", en, addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h8 || instr !== 32'h1000_0002 || vld !== 1'b1 || en !== 1'b0)
        begin failures++; $display("FAIL stall_hold%0d got pc=%h instr=%h vld=%b en=%b want 8/10000002/1/0", i, pc, instr, vld, en); end
    end
    stall_i = 0; #1;
    checks++; if (en !== 1'b1 || addr !== 32'hC || instr !== 32'h1000_0002) begin failures++; $display("FAIL stall_rel got en=%b addr=%h instr=%h want 1/c/10000002", en, addr, instr); end
    step();
    checks++; if (pc !== 32'hC || instr !== 32'h1000_0003) begin failures++; $display("FAIL stall_after got pc=%h instr=%h want c/10000003", pc, instr); end
  endtask

  task automatic test_redirect();
    redir_v = 1; redir_pc = 32'h0000_0103; #1;
    checks++; if (addr !== 32'h100 || en !== 1'b1) begin failures++; $display("FAIL redir_bypass got addr=%h en=%b want 100/1", addr, en); end
    step(); redir_v = 0; #1;
    checks++; if (pc !== 32'h100 || pc4 !== 32'h104 || instr !== 32'h1000_0040) begin failures++; $display("FAIL redir_id got pc=%h pc4=%h instr=%h want 100/104/10000040", pc, pc4, instr); end
    step();
    checks++; if (pc !== 32'h104 || instr !== 32'h1000_0041) begin failures++; $display("FAIL redir_next got pc=%h instr=%h want 104/10000041", pc, instr); end
  endtask

  task automatic test_redirect_stall();
    stall_i = 1; step(); step();
    checks++; if (pc !== 32'h104 || instr !== 32'h1000_0041) begin failures++; $display("FAIL rs_hold got pc=%h instr=%h want 104/10000041", pc, instr); end
    redir_v = 1; redir_pc = 32'h40; #1;
    checks++; if (en !== 1'b1 || addr !== 32'h40) begin failures++; $display("FAIL rs_fetch got en=%b addr=%h want 1/40", en, addr); end
    step(); redir_v = 0; stall_i = 0; #1;
    checks++; if (pc !== 32'h40 || instr !== 32'h1000_0010 || vld !== 1'b1) begin failures++; $display("FAIL rs_id got pc=%h instr=%h vld=%b want 40/10000010/1", pc, instr, vld); end
  endtask

  task automatic test_back_to_back();
    redir_v = 1; redir_pc = 32'h200; #1;
    checks++; if (addr !== 32'h200) begin failures++; $display("FAIL b2b_a0 got=%h want=200", addr); end
    step(); redir_pc = 32'h306; #1;
    checks++; if (addr !== 32'h304 || pc !== 32'h200 || instr !== 32'h1000_0080) begin failures++; $display("FAIL b2b_a1 got addr=%h pc=%h instr=%h want 304/200/10000080", addr, pc, instr); end
    step(); redir_v = 0; #1;
    checks++; if (pc !== 32'h304 || instr !== 32'h1000_00C1) begin failures++; $display("FAIL b2b_id got pc=%h instr=%h want 304/100000c1", pc, instr); end
    step();
    checks++; if (pc !== 32'h308 || instr !== 32'h1000_00C2) begin failures++; $display("FAIL b2b_next got pc=%h instr=%h want 308/100000c2", pc, instr); end
  endtask

  task automatic test_reset_during_stall();
    stall_i = 1; step();
    rst_n = 0; #1;
    checks++; if (en !== 1'b0 || vld !== 1'b0 || instr !== 32'h0000_0013 || pc !== 32'h0) begin failures++; $display("FAIL rds_now got en=%b vld=%b instr=%h pc=%h want 0/0/00000013/0", en, vld, instr, pc); end
    step();
    checks++; if (en !== 1'b0 || vld !== 1'b0 || instr !== 32'h0000_0013) begin failures++; $display("FAIL rds_edge got en=%b vld=%b instr=%h want 0/0/00000013", en, vld, instr); end
    stall_i = 0; step(); rst_n = 1; #1;
    checks++; if (addr !== 32'h0 || en !== 1'b1 || vld !== 1'b0) begin failures++; $display("FAIL rds_rel got addr=%h en=%b vld=%b want 0/1/0", addr, en, vld); end
    step();
    checks++; if (pc !== 32'h0 || vld !== 1'b1 || instr !== 32'h1000_0000) begin failures++; $display("FAIL rds_first got pc=%h vld=%b instr=%h want 0/1/10000000", pc, vld, instr); end
  endtask

  task automatic test_wrap();
    stall_i = 0; redir_v = 0; rst2_n = 1; #1;
    checks++; if (addr2 !== 32'hFFFF_FFF8 || en2 !== 1'b1) begin failures++; $display("FAIL wrap_fetch got addr=%h en=%b want fffffff8/1", addr2, en2); end
    step();
    checks++; if (pc2 !== 32'hFFFF_FFF8 || instr2 !== 32'h4FFF_FFFE) begin failures++; $display("FAIL wrap0 got pc=%h instr=%h want fffffff8/4ffffffe", pc2, instr2); end
    step();
    checks++; if (pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0 || instr2 !== 32'h4FFF_FFFF) begin failures++; $display("FAIL wrap1 got pc=%h pc4=%h instr=%h want fffffffc/0/4fffffff", pc2, pc42, instr2); end
    step();
    checks++; if (pc2 !== 32'h0 || instr2 !== 32'h1000_0000) begin failures++; $display("FAIL wrap2 got pc=%h instr=%h want 0/10000000", pc2, instr2); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_reset_during_stall();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the core pipeline: owns the program counter, drives the synchronous instruction memory (1-cycle read latency), and presents `pc/instr/valid` to the ID stage. Consumes `stall_o` from `hazard_detection_unit` to freeze IF and ID. Consumes the taken-branch/jump redirect from EX. Keeps the ID-stage instruction stable across a stall with a one-entry hold buffer, so stall correctness never depends on memory output behaviour.

## Interface
- `XLEN`, default 32, address/data width; taken from `core_pkg`.
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `clk  in  1  clock`
- `rst_n  in  1  reset, synchronous, active-low`
- `stall_i  in  1  freeze IF and ID; driven by hazard_detection_unit stall_o`
- `redirect_valid_i  in  1  EX resolved a taken branch/jump this cycle`
- `redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and treated as 00`
- `imem_en_o  out  1  instruction memory read enable`
- `imem_addr_o  out  XLEN  instruction memory byte address, word aligned`
- `imem_rdata_i  in  32  read data for the address accepted on the previous cycle`
- `pc_ID_o  out  XLEN  PC of the instruction in ID`
- `pc_plus4_ID_o  out  XLEN  pc_ID_o + 4, wrapping`
- `instr_ID_o  out  32  instruction in ID; NOP_INSTR when not valid`
- `valid_ID_o  out  1  ID holds a real fetched instruction`

## Operation
- State registers:
  - `pc_F`: next address to issue.
  - `pc_ID`, `valid_ID`.
  - `hold_vld`, `hold_instr`.
- Mode priority: reset > redirect > stall > normal.
- Normal mode (`!stall_i`, `!redirect_valid_i`):
  - Outputs: `imem_en_o=1`, `imem_addr_o=pc_F`.
  - Updates: `pc_F<=pc_F+4`, `pc_ID<=pc_F`, `valid_ID<=1`, `hold_vld<=0`.
- Redirect mode (`redirect_valid_i`; `stall_i` ignored):
  - Outputs: `imem_en_o=1`, `imem_addr_o={redirect_pc_i[XLEN-1:2],2'b00}`. This is a combinational bypass, so the target is fetched in the same cycle.
  - Updates: `pc_F<=target+4`, `pc_ID<=target`, `valid_ID<=1`, `hold_vld<=0`.
  - Squashing the wrong-path instruction currently in ID is the job of the ID/EX register flush, not this block.
- Stall mode (`stall_i`, no redirect):
  - Outputs: `imem_en_o=0`, `imem_addr_o=pc_F`.
  - `pc_F`, `pc_ID`, `valid_ID` hold.
  - If `!hold_vld`: `hold_instr<=imem_rdata_i`, `hold_vld<=1`. If `hold_vld`: hold buffer unchanged.
- `instr_ID_o` source:
  - `!valid_ID` → `NOP_INSTR`.
  - else `hold_vld` → `hold_instr`.
  - else → `imem_rdata_i`.
- `pc_plus4_ID_o = pc_ID + 4`.
- Arithmetic: all PC adds are modulo 2^XLEN. 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - Registers: `pc_F=RESET_PC`, `pc_ID=0`, `valid_ID=0`, `hold_vld=0`, `hold_instr=0`.
  - While `rst_n=0`: `imem_en_o=0`, `valid_ID_o=0`, `instr_ID_o=NOP_INSTR`, `pc_ID_o=0`, `pc_plus4_ID_o=4`.
  - A reset asserted mid-stall or mid-redirect discards all state the same way.
- First cycle after reset release: `imem_addr_o=RESET_PC`, `imem_en_o=1`. `valid_ID_o` rises one cycle later.
- Fetch-to-ID latency: 1 cycle. Steady-state throughput: 1 instruction per cycle.
- Redirect penalty inside this block: 0 extra cycles. Target appears in ID on the cycle after `redirect_valid_i`.
- Stall of N cycles:
  - ID output is frozen for N cycles.
  - On the cycle after `stall_i` falls, ID shows the instruction at old `pc_F`. No instruction is lost or duplicated.
- Stall asserted while `valid_ID=0`: NOP output is held and the hold buffer may load. The captured value is unused until `valid_ID=1` and is cleared on the next advance.
- Stall and redirect in the same cycle: redirect wins, and the hold buffer clears.
- Back-to-back redirects: each cycle's target is fetched, and the last one wins.

## Structure
- `core_pkg` additions:
  - `XLEN` (alias of the existing data width).
  - `RESET_PC`.
  - `NOP_INSTR = 32'h0000_0013` (addi x0,x0,0).
- One natural sub-module: `fetch_hold_buffer`.
  - Contents: `hold_vld`/`hold_instr` plus the `instr_ID_o` mux.
  - Inputs: `clk`, `rst_n`, `stall`, `flush`, `rdata`.
- The PC logic stays in the top module.

## Test plan
- Reset release, no stall, ROM word i = 32'h1000_0000+i:
  - Cycle 1: `imem_addr_o` = 0x0.
  - Cycle 2: `instr_ID_o`=32'h1000_0000, `pc_ID_o`=0x0, `valid_ID_o`=1.
  - Then `pc_ID_o` steps by 4 each cycle.
- `stall_i` high for 3 cycles while ID holds pc 0x8:
  - `instr_ID_o`=32'h1000_0002 and `pc_ID_o`=0x8 are stable, and `imem_en_o`=0.
  - The ROM is driven to 32'hDEAD_BEEF while `imem_en_o`=0; ID output is unaffected.
  - The cycle after release shows pc 0xC, instruction 32'h1000_0003.
- `redirect_valid_i=1`, `redirect_pc_i`=0x0000_0103:
  - Same cycle: `imem_addr_o`=0x100.
  - Next cycle: `pc_ID_o`=0x100, `pc_plus4_ID_o`=0x104.
- `redirect_valid_i` and `stall_i` both high, target 0x40: redirect taken; next cycle `pc_ID_o`=0x40 and the hold buffer is empty.
- `RESET_PC`=32'hFFFF_FFF8 with a free run: `pc_ID_o` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted during a 2-cycle stall: next cycle `valid_ID_o`=0, `instr_ID_o`=0x0000_0013, `imem_en_o`=0.
